// File: rtl/sirv_gnrl_xmonitor.sv
// sirv_gnrl_xmonitor: multi-channel valid-qualified X monitor with holdoff, first-error capture and error count.
module sirv_gnrl_xmonitor #(
  parameter int DW       = 32,
  parameter int CH       = 4,
  parameter int CHW      = 2,
  parameter int CNTW     = 16,
  parameter int HOLDOFF  = 8,
  parameter int FATAL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    i_vld,
  input  logic [CH*DW-1:0] i_dat,
  input  logic             i_clr,
  output logic             o_armed,
  output logic             o_err,
  output logic [CHW-1:0]   o_err_ch,
  output logic [CNTW-1:0]  o_err_cyc,
  output logic [CNTW-1:0]  o_err_cnt
);
  typedef enum logic [1:0] {HOLD, ARMED, ERRORED} state_t;
  localparam int HW = HOLDOFF > 2 ? $clog2(HOLDOFF) : 1;
  state_t state, state_nxt;
  logic [HW-1:0] hold_cnt;
  logic [CNTW-1:0] cyc_cnt;
  logic [CH-1:0] ch_err;
  logic [CHW-1:0] first_ch;
  logic hold_done, any_err, capture;
  // descending scan so the lowest erroring channel is the one left in first_ch
  always_comb begin
    ch_err = '0;
    first_ch = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      ch_err[k] = $isunknown(i_vld[k]) || (i_vld[k] === 1'b1 && $isunknown(i_dat[k*DW +: DW]));
      if (ch_err[k]) first_ch = CHW'(k);
    end
  end
  assign hold_done = (HOLDOFF <= 1) || (hold_cnt == HW'(HOLDOFF - 1));
  assign any_err = (state != HOLD) && (|ch_err);
  // a clear in the same cycle as an error re-opens the capture window
  assign capture = any_err && (state == ARMED || i_clr);
  always_comb begin
    state_nxt = state;
    state_nxt = state == HOLD ? (hold_done ? ARMED : HOLD)
              : any_err ? ERRORED
              : i_clr ? ARMED : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= HOLD;
      hold_cnt <= '0;
      cyc_cnt <= '0;
      o_err_ch <= '0;
      o_err_cyc <= '0;
      o_err_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
      else cyc_cnt <= cyc_cnt + CNTW'(~&cyc_cnt);
      if (capture) begin
        o_err_ch <= first_ch;
        o_err_cyc <= cyc_cnt;
      end else if (i_clr && state == ERRORED) begin
        o_err_ch <= '0;
        o_err_cyc <= '0;
      end
      o_err_cnt <= any_err ? (i_clr ? CNTW'(1) : o_err_cnt + CNTW'(~&o_err_cnt))
                 : i_clr ? '0 : o_err_cnt;
    end
  end
  assign o_armed = state != HOLD;
  assign o_err = state == ERRORED;
`ifndef FPGA_SOURCE
`ifndef DISABLE_SV_ASSERTION
  always @(posedge clk) begin
    if (!rst && state == ARMED && any_err) begin
      $display("sirv_gnrl_xmonitor: X on channel %0d at armed cycle %0d", first_ch, cyc_cnt);
      if (FATAL_EN != 0) $fatal(1, "sirv_gnrl_xmonitor: aborting on X");
    end
  end
`endif
`endif
endmodule

// File: doc/sirv_gnrl_xmonitor.md
Name: sirv_gnrl_xmonitor

Overview:
- Parametrised, multi-channel, valid-qualified X monitor; next generation of the single-vector X checker.
- Watches CH data channels, each DW bits wide, after a programmable post-reset holdoff.
- Counts X events, captures the first offending channel and the cycle it occurred in, and either aborts simulation or only records, depending on mode.
- Simulation-only instrument: wrapped in the same FPGA_SOURCE / DISABLE_SV_ASSERTION / translate_off guards as other checkers; instantiated beside bus/FIFO interfaces.

Parameters:
- DW, 32: data width per channel.
- CH, 4: number of channels.
- CHW, 2: width of the channel index; must satisfy 2**CHW >= CH.
- CNTW, 16: width of the error counter and the cycle counter.
- HOLDOFF, 8: cycles after reset release before checking starts; 0 = check from the first cycle.
- FATAL_EN, 1: 1 = $fatal on the first detected error; 0 = record only.

Ports:
- clk, input, 1: clock.
- rst, input, 1: asynchronous, active-high reset.
- i_vld, input, CH: per-channel valid; bit k qualifies channel k.
- i_dat, input, CH*DW: channel k occupies bits [k*DW +: DW].
- i_clr, input, 1: synchronous clear of error status.
- o_armed, output, 1: checking active (holdoff elapsed).
- o_err, output, 1: sticky error flag.
- o_err_ch, output, CHW: channel index of the first error.
- o_err_cyc, output, CNTW: armed-cycle count at the first error.
- o_err_cnt, output, CNTW: saturating count of error events.

Behaviour:
- Reset values (asynchronous, while rst=1): o_armed=0, o_err=0, o_err_ch=0, o_err_cyc=0, o_err_cnt=0, holdoff counter=0, cycle counter=0, state=HOLD.
- States and transitions:
  - HOLD: holdoff counter increments each clk. Go to ARMED on the edge where the count reaches HOLDOFF-1. If HOLDOFF=0, go to ARMED on the first posedge after reset release.
  - ARMED: o_armed=1. Go to ERRORED on any error event.
  - ERRORED: o_armed=1, o_err=1. Return to ARMED on i_clr.
- Cycle counter: increments every ARMED/ERRORED cycle; saturates at all-ones.
- Error conditions, sampled at posedge clk, only in ARMED/ERRORED:
  - per channel k: (^i_vld[k]) === 1'bx, i.e. valid itself is X/Z, whether or not data is clean;
  - or i_vld[k]===1 and (^i_dat[k*DW +: DW]) === 1'bx.
  - Data on channels with i_vld[k]=0 is ignored.
  - HOLD never flags, even for X inputs.
- Error event: one or more channels in error in a cycle. o_err_cnt adds exactly 1 per event cycle, regardless of how many channels are in error, and saturates at all-ones (no wrap).
- First-error capture:
  - Captured on the ARMED->ERRORED transition only.
  - o_err_ch = lowest-index erroring channel; o_err_cyc = cycle counter value in that cycle.
  - Later errors do not overwrite these fields.
- Output latency: registered, one cycle. Error sampled at edge N is visible after edge N.
- i_clr in ERRORED without a same-cycle error: state becomes ARMED; o_err, o_err_ch, o_err_cyc and o_err_cnt are zeroed. The cycle counter is not cleared.
- i_clr and an error event in the same cycle: the error wins. State = ERRORED, o_err_cnt=1, and o_err_ch / o_err_cyc are recaptured from this cycle.
- i_clr in HOLD or ARMED: no effect apart from zeroing o_err_cnt.
- FATAL_EN=1: on the first ARMED->ERRORED transition, $display the channel and the cycle, then $fatal. FATAL_EN=0: silent recording plus one $display per first error.
- Reset mid-operation: all state is lost immediately; HOLD restarts with the full HOLDOFF count.

Test Plan:
- Reset release, HOLDOFF=8, i_vld=4'b1111 with X data from cycle 0 -> o_armed rises after edge 8; first error at edge 9; o_err_cnt=1, o_err_cyc=0.
- FATAL_EN=0, ARMED; channel 2 data X with i_vld[2]=0 for 5 cycles -> o_err stays 0, o_err_cnt=0. Then i_vld[2]=1 -> o_err=1, o_err_ch=2 on the next cycle.
- Channels 1 and 3 both X-valid in the same cycle, then channel 0 X next cycle -> o_err_ch=1, o_err_cnt=2.
- CNTW=4, continuous X for 20 cycles -> o_err_cnt holds 15, no wrap. i_clr with no error -> all error fields 0, state ARMED.
- i_clr asserted in the same cycle as a channel-3 X -> o_err=1, o_err_ch=3, o_err_cnt=1.
- FATAL_EN=1, i_vld[0]=1'bx in ARMED -> simulation ends with $fatal on that edge. rst pulse in the middle of HOLD -> holdoff restarts from 0.
